// File: rtl/systolic_pe_ws.sv
// Weight-stationary systolic PE: double-buffered weight (shadow shift chain + active),
// one registered MAC per cycle with optional saturation and a sticky overflow flag.
module systolic_pe_ws #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  w_load_valid,
    input  logic [DATA_WIDTH-1:0] w_load_data,
    input  logic                  w_swap,
    output logic                  w_out_valid,
    output logic [DATA_WIDTH-1:0] w_out_data,
    input  logic                  a_in_valid,
    input  logic [DATA_WIDTH-1:0] a_in_data,
    input  logic [ACC_WIDTH-1:0]  ps_in,
    output logic                  a_out_valid,
    output logic [DATA_WIDTH-1:0] a_out_data,
    output logic                  ps_out_valid,
    output logic [ACC_WIDTH-1:0]  ps_out,
    output logic                  shadow_full,
    output logic                  ovf,
    input  logic                  clr_ovf
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                  sgn;
    assign sgn = (SIGNED != 0);

    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic                  shadow_full_q, shadow_full_d;
    logic                  w_out_valid_q;
    logic [DATA_WIDTH-1:0] w_out_data_q, w_out_data_d;
    logic                  a_out_valid_q;
    logic [DATA_WIDTH-1:0] a_out_data_q, a_out_data_d;
    logic                  ps_out_valid_q;
    logic [ACC_WIDTH-1:0]  ps_out_q, ps_out_d;
    logic                  ovf_q, ovf_d;

    logic [PW-1:0]         a_ext, w_ext, prod;
    logic [SW-1:0]         prod_ext, ps_ext, sum;
    logic                  ovf_now;
    logic                  swap_en;
    logic [ACC_WIDTH-1:0]  sat_val, mac_res;

    // Both operands are widened to the product width first, so one multiplier
    // yields the correct low 2*DATA_WIDTH bits for signed and unsigned modes.
    always_comb begin
        a_ext    = {{DATA_WIDTH{sgn & a_in_data[DATA_WIDTH-1]}}, a_in_data};
        w_ext    = {{DATA_WIDTH{sgn & active_q[DATA_WIDTH-1]}}, active_q};
        prod     = a_ext * w_ext;
        prod_ext = {{(SW-PW){sgn & prod[PW-1]}}, prod};
        ps_ext   = {sgn & ps_in[ACC_WIDTH-1], ps_in};
        sum      = prod_ext + ps_ext;
    end

    // One guard bit is enough: the product magnitude never exceeds half the accumulator range.
    always_comb begin
        if (sgn) begin
            ovf_now = sum[SW-1] ^ sum[SW-2];
            sat_val = sum[SW-1] ? SMIN : SMAX;
        end else begin
            ovf_now = sum[SW-1];
            sat_val = UMAX;
        end
        if (ovf_now && (SATURATE != 0)) mac_res = sat_val;
        else                            mac_res = sum[ACC_WIDTH-1:0];
    end

    // NOTE: every next-state signal gets a hold default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        swap_en       = w_swap & shadow_full_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        shadow_full_d = shadow_full_q;
        w_out_data_d  = w_out_data_q;
        a_out_data_d  = a_out_data_q;
        ps_out_d      = ps_out_q;
        ovf_d         = ovf_q;

        if (swap_en) begin
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
        end
        if (w_load_valid) begin
            shadow_d      = w_load_data;
            w_out_data_d  = shadow_q;
            shadow_full_d = 1'b1;
        end

        if (clr_ovf) ovf_d = 1'b0;
        if (a_in_valid) begin
            a_out_data_d = a_in_data;
            ps_out_d     = mac_res;
            if (ovf_now) ovf_d = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q       <= '0;
            active_q       <= '0;
            shadow_full_q  <= 1'b0;
            w_out_valid_q  <= 1'b0;
            w_out_data_q   <= '0;
            a_out_valid_q  <= 1'b0;
            a_out_data_q   <= '0;
            ps_out_valid_q <= 1'b0;
            ps_out_q       <= '0;
            ovf_q          <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            shadow_full_q  <= shadow_full_d;
            w_out_valid_q  <= w_load_valid;
            w_out_data_q   <= w_out_data_d;
            a_out_valid_q  <= a_in_valid;
            a_out_data_q   <= a_out_data_d;
            ps_out_valid_q <= a_in_valid;
            ps_out_q       <= ps_out_d;
            ovf_q          <= ovf_d;
        end
    end

    assign w_out_valid  = w_out_valid_q;
    assign w_out_data   = w_out_data_q;
    assign a_out_valid  = a_out_valid_q;
    assign a_out_data   = a_out_data_q;
    assign ps_out_valid = ps_out_valid_q;
    assign ps_out       = ps_out_q;
    assign shadow_full  = shadow_full_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_systolic_pe_ws.sv
// Bench for systolic_pe_ws: three instances (unsigned saturating, unsigned wrapping,
// signed saturating) share weight/data inputs; each has its own activation valid.
module tb_systolic_pe_ws;

    logic        clk = 1'b0;
    logic        rstn;
    logic        w_load_valid, w_swap, clr_ovf;
    logic [7:0]  w_load_data, a_data;
    logic [19:0] ps_in;
    logic        av0, av1, av2;

    logic [2:0]  wov, aov, pov, sf, ovf;
    logic [7:0]  wod [3];
    logic [7:0]  aod [3];
    logic [19:0] po  [3];

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [19:0] q2[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_pe_ws #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(1)) dut0 (
        .clk(clk), .rstn(rstn),
        .w_load_valid(w_load_valid), .w_load_data(w_load_data), .w_swap(w_swap),
        .w_out_valid(wov[0]), .w_out_data(wod[0]),
        .a_in_valid(av0), .a_in_data(a_data), .ps_in(ps_in),
        .a_out_valid(aov[0]), .a_out_data(aod[0]),
        .ps_out_valid(pov[0]), .ps_out(po[0]),
        .shadow_full(sf[0]), .ovf(ovf[0]), .clr_ovf(clr_ovf)
    );

    systolic_pe_ws #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(0)) dut1 (
        .clk(clk), .rstn(rstn),
        .w_load_valid(w_load_valid), .w_load_data(w_load_data), .w_swap(w_swap),
        .w_out_valid(wov[1]), .w_out_data(wod[1]),
        .a_in_valid(av1), .a_in_data(a_data), .ps_in(ps_in),
        .a_out_valid(aov[1]), .a_out_data(aod[1]),
        .ps_out_valid(pov[1]), .ps_out(po[1]),
        .shadow_full(sf[1]), .ovf(ovf[1]), .clr_ovf(clr_ovf)
    );

    systolic_pe_ws #(.DATA_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1), .SATURATE(1)) dut2 (
        .clk(clk), .rstn(rstn),
        .w_load_valid(w_load_valid), .w_load_data(w_load_data), .w_swap(w_swap),
        .w_out_valid(wov[2]), .w_out_data(wod[2]),
        .a_in_valid(av2), .a_in_data(a_data), .ps_in(ps_in),
        .a_out_valid(aov[2]), .a_out_data(aod[2]),
        .ps_out_valid(pov[2]), .ps_out(po[2]),
        .shadow_full(sf[2]), .ovf(ovf[2]), .clr_ovf(clr_ovf)
    );

    // Scoreboard: each valid partial sum is matched against the oldest expected value.
    always @(negedge clk) begin
        logic [19:0] e;
        if (pov[0] === 1'b1) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++; $display("FAIL sb0_unexpected: ps_out=%h, expected no output", po[0]);
            end else begin
                e = q0.pop_front();
                if (po[0] !== e) begin n_err++; $display("FAIL sb0_ps_out: got %h expected %h", po[0], e); end
            end
        end
        if (pov[1] === 1'b1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++; $display("FAIL sb1_unexpected: ps_out=%h, expected no output", po[1]);
            end else begin
                e = q1.pop_front();
                if (po[1] !== e) begin n_err++; $display("FAIL sb1_ps_out: got %h expected %h", po[1], e); end
            end
        end
        if (pov[2] === 1'b1) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_err++; $display("FAIL sb2_unexpected: ps_out=%h, expected no output", po[2]);
            end else begin
                e = q2.pop_front();
                if (po[2] !== e) begin n_err++; $display("FAIL sb2_ps_out: got %h expected %h", po[2], e); end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_w(input logic [7:0] w);
        w_load_valid = 1'b1; w_load_data = w;
        step();
        w_load_valid = 1'b0;
    endtask

    task automatic do_swap();
        w_swap = 1'b1;
        step();
        w_swap = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        rstn = 1'b0;
        w_load_valid = 0; w_load_data = 0; w_swap = 0; clr_ovf = 0;
        a_data = 0; ps_in = 0; av0 = 0; av1 = 0; av2 = 0;
        #23;
        for (int i = 0; i < 3; i++) begin
            outs = {pov[i], po[i], aov[i], aod[i], wov[i], wod[i], sf[i], ovf[i]};
            n_cmp++;
            if (outs !== 41'd0) begin n_err++; $display("FAIL reset_outputs dut%0d: got %h expected 0", i, outs); end
        end
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_load_mac();
        load_w(8'd3);
        n_cmp++; if (sf[0] !== 1'b1) begin n_err++; $display("FAIL load_shadow_full: got %b expected 1", sf[0]); end
        do_swap();
        n_cmp++; if (sf[0] !== 1'b0) begin n_err++; $display("FAIL swap_shadow_full: got %b expected 0", sf[0]); end
        a_data = 8'd5; ps_in = 20'd10; av0 = 1'b1; q0.push_back(20'd25);
        step();
        av0 = 1'b0;
        n_cmp++; if (aov[0] !== 1'b1) begin n_err++; $display("FAIL mac_a_out_valid: got %b expected 1", aov[0]); end
        n_cmp++; if (aod[0] !== 8'd5) begin n_err++; $display("FAIL mac_a_out_data: got %0d expected 5", aod[0]); end
        step();
        n_cmp++; if (pov[0] !== 1'b0) begin n_err++; $display("FAIL idle_ps_out_valid: got %b expected 0", pov[0]); end
        n_cmp++; if (po[0] !== 20'd25) begin n_err++; $display("FAIL idle_ps_out_hold: got %h expected 25", po[0]); end
        n_cmp++; if (aov[0] !== 1'b0 || aod[0] !== 8'd5) begin
            n_err++; $display("FAIL idle_a_out: got valid=%b data=%0d expected 0/5", aov[0], aod[0]);
        end
    endtask

    task automatic test_shift_chain();
        load_w(8'd7);
        load_w(8'd9);
        n_cmp++; if (wov[0] !== 1'b1) begin n_err++; $display("FAIL chain_w_out_valid: got %b expected 1", wov[0]); end
        n_cmp++; if (wod[0] !== 8'd7) begin n_err++; $display("FAIL chain_w_out_data: got %0d expected 7", wod[0]); end
        step();
        n_cmp++; if (wov[0] !== 1'b0) begin n_err++; $display("FAIL chain_w_out_idle: got %b expected 0", wov[0]); end
        load_w(8'd1);
        n_cmp++; if (wod[0] !== 8'd9) begin n_err++; $display("FAIL chain_shadow_9: got %0d expected 9", wod[0]); end
    endtask

    task automatic test_collision();
        load_w(8'd2);
        do_swap();
        load_w(8'd4);
        w_swap = 1'b1; a_data = 8'd3; ps_in = 20'd0; av0 = 1'b1; q0.push_back(20'd6);
        step();
        w_swap = 1'b0; q0.push_back(20'd12);
        step();
        av0 = 1'b0;
        step();
        n_cmp++; if (sf[0] !== 1'b0) begin n_err++; $display("FAIL collision_shadow_full: got %b expected 0", sf[0]); end
    endtask

    task automatic test_overflow();
        load_w(8'd255);
        do_swap();
        a_data = 8'd255; ps_in = 20'hF01FE; av0 = 1; av1 = 1;
        q0.push_back(20'hFFFFF); q1.push_back(20'hFFFFF);
        step();
        av0 = 0; av1 = 0;
        n_cmp++; if (ovf[0] !== 1'b0 || ovf[1] !== 1'b0) begin
            n_err++; $display("FAIL ovf_exact_max: got %b%b expected 00", ovf[0], ovf[1]);
        end
        ps_in = 20'hFFFFF; av0 = 1; av1 = 1;
        q0.push_back(20'hFFFFF); q1.push_back(20'h0FE00);
        step();
        av0 = 0; av1 = 0;
        n_cmp++; if (ovf[0] !== 1'b1 || ovf[1] !== 1'b1) begin
            n_err++; $display("FAIL ovf_set: got %b%b expected 11", ovf[0], ovf[1]);
        end
        step();
        n_cmp++; if (ovf[0] !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", ovf[0]); end
        clr_ovf = 1;
        step();
        clr_ovf = 0;
        n_cmp++; if (ovf[0] !== 1'b0 || ovf[1] !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear: got %b%b expected 00", ovf[0], ovf[1]);
        end
        clr_ovf = 1; av0 = 1; q0.push_back(20'hFFFFF);
        step();
        clr_ovf = 0; av0 = 0;
        n_cmp++; if (ovf[0] !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b expected 1", ovf[0]); end
        clr_ovf = 1;
        step();
        clr_ovf = 0;
        n_cmp++; if (ovf[0] !== 1'b0) begin n_err++; $display("FAIL ovf_clear2: got %b expected 0", ovf[0]); end
    endtask

    task automatic test_signed();
        load_w(8'hFE);
        do_swap();
        a_data = 8'd3; ps_in = 20'hFFFFF; av2 = 1; q2.push_back(20'hFFFF9);
        step();
        av2 = 0;
        n_cmp++; if (ovf[2] !== 1'b0) begin n_err++; $display("FAIL signed_no_ovf: got %b expected 0", ovf[2]); end
        load_w(8'h80);
        do_swap();
        a_data = 8'h80; ps_in = 20'd0; av2 = 1; q2.push_back(20'h04000);
        step();
        av2 = 0;
        n_cmp++; if (ovf[2] !== 1'b0) begin n_err++; $display("FAIL signed_negneg_no_ovf: got %b expected 0", ovf[2]); end
        load_w(8'hFF);
        do_swap();
        a_data = 8'd1; ps_in = 20'h80000; av2 = 1; q2.push_back(20'h80000);
        step();
        av2 = 0;
        n_cmp++; if (ovf[2] !== 1'b1) begin n_err++; $display("FAIL signed_min_clamp_ovf: got %b expected 1", ovf[2]); end
        load_w(8'h7F);
        do_swap();
        a_data = 8'h7F; ps_in = 20'h7FFFF; av2 = 1; q2.push_back(20'h7FFFF);
        step();
        av2 = 0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  w1, w2, cur_w, a;
        logic [19:0] p;
        longint      s;
        w1 = 8'($urandom_range(1, 255));
        w2 = 8'($urandom_range(1, 255));
        load_w(w1);
        do_swap();
        load_w(w2);
        cur_w = w1;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            p = (i % 4 == 3) ? 20'($urandom_range(20'hF0000, 20'hFFFFF)) : 20'($urandom_range(0, 20'hFFFFF));
            a_data = a; ps_in = p; av0 = 1; w_swap = (i == 12);
            s = longint'(p) + longint'(a) * longint'(cur_w);
            q0.push_back((s > 64'hFFFFF) ? 20'hFFFFF : 20'(s));
            if (i == 12) cur_w = w2;
            step();
        end
        av0 = 0; w_swap = 0;
        step();
        n_cmp++; if (sf[0] !== 1'b0) begin n_err++; $display("FAIL b2b_shadow_full: got %b expected 0", sf[0]); end
        clr_ovf = 1;
        step();
        clr_ovf = 0;
    endtask

    task automatic test_reset_mid();
        logic [40:0] outs;
        load_w(8'd6);
        do_swap();
        load_w(8'd8);
        a_data = 8'd255; ps_in = 20'hFFFFF; av0 = 1; q0.push_back(20'hFFFFF);
        step();
        a_data = 8'd2; ps_in = 20'd1; q0.push_back(20'd13);
        step();
        q0.push_back(20'd13);
        step();
        @(negedge clk); #2;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            outs = {pov[i], po[i], aov[i], aod[i], wov[i], wod[i], sf[i], ovf[i]};
            n_cmp++;
            if (outs !== 41'd0) begin n_err++; $display("FAIL midreset_outputs dut%0d: got %h expected 0", i, outs); end
        end
        av0 = 0;
        step();
        rstn = 1'b1;
        step();
        do_swap();
        n_cmp++; if (sf[0] !== 1'b0) begin n_err++; $display("FAIL midreset_swap_ignored: got %b expected 0", sf[0]); end
        a_data = 8'd9; ps_in = 20'd4; av0 = 1; q0.push_back(20'd4);
        step();
        av0 = 0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_load_mac();
        test_shift_chain();
        test_collision();
        test_overflow();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        n_cmp++; if (q0.size() != 0) begin n_err++; $display("FAIL sb0_pending: got %0d left expected 0", q0.size()); end
        n_cmp++; if (q1.size() != 0) begin n_err++; $display("FAIL sb1_pending: got %0d left expected 0", q1.size()); end
        n_cmp++; if (q2.size() != 0) begin n_err++; $display("FAIL sb2_pending: got %0d left expected 0", q2.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
